// File: rtl/nnrv_trace_pkg.sv
// Shared types and constants for the nnrv retire-trace UART transmitter.
package nnrv_trace_pkg;

  localparam int unsigned TRACE_XLEN        = 32;
  localparam int unsigned TRACE_REC_W       = 2 * TRACE_XLEN;
  localparam logic [7:0]  TRACE_SYNC        = 8'hA5;
  localparam int unsigned TRACE_FRAME_BYTES = 9;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } trace_state_e;

  // Byte 0 is the sync marker; bytes 1..8 walk the record {instr, pc} little-endian.
  function automatic logic [7:0] trace_byte(input logic [TRACE_REC_W-1:0] rec,
                                            input logic [3:0]             idx);
    logic [7:0] b;
    case (idx)
      4'd1:    b = rec[7:0];
      4'd2:    b = rec[15:8];
      4'd3:    b = rec[23:16];
      4'd4:    b = rec[31:24];
      4'd5:    b = rec[39:32];
      4'd6:    b = rec[47:40];
      4'd7:    b = rec[55:48];
      4'd8:    b = rec[63:56];
      default: b = TRACE_SYNC;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/nnrv_trace_fifo.sv
// Synchronous FIFO for retire records. Push while full is accepted only when a
// pop happens on the same edge; pop while empty is ignored.
module nnrv_trace_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/nnrv_trace_tx.sv
// Retire-trace transmitter: buffers (pc, instr) records and sends each as a
// 9-byte frame (0xA5, pc LE, instr LE) on a UART 8N1 line.
module nnrv_trace_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned XLEN         = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_trace_valid,
  input  logic [XLEN-1:0] i_trace_pc,
  input  logic [XLEN-1:0] i_trace_instr,
  output logic            o_tx,
  output logic            o_trace_full,
  output logic            o_busy,
  output logic [7:0]      o_drop_cnt
);

  import nnrv_trace_pkg::*;

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    BYTE_LAST = 4'(TRACE_FRAME_BYTES - 1);

  trace_state_e           state_q;
  logic [BW-1:0]          baud_q;
  logic [2:0]             bit_q;
  logic [3:0]             byte_q;
  logic [TRACE_REC_W-1:0] hold_q;
  logic                   tx_q;
  logic [7:0]             drop_q;

  logic [TRACE_REC_W-1:0] fifo_rdata;
  logic                   fifo_full, fifo_empty, pop;
  logic [CW-1:0]          fifo_count;
  logic [7:0]             cur_byte;
  logic [2:0]             next_bit;
  logic                   baud_last;

  assign pop       = (state_q == StIdle) && !fifo_empty;
  assign cur_byte  = trace_byte(hold_q, byte_q);
  assign next_bit  = bit_q + 3'd1;
  assign baud_last = (baud_q == BAUD_LAST);

  nnrv_trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TRACE_REC_W)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (i_trace_valid),
    .wdata_i ({i_trace_instr, i_trace_pc}),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Frame serializer; tx is assigned alongside each transition so the line is glitch-free.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      hold_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (pop) begin
            hold_q  <= fifo_rdata;
            byte_q  <= '0;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= cur_byte[0];
            state_q <= StData;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StData: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_q <= next_bit;
              tx_q  <= cur_byte[next_bit];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        StStop: begin
          if (baud_last) begin
            baud_q <= '0;
            if (byte_q == BYTE_LAST) begin
              tx_q    <= 1'b1;
              state_q <= StIdle;
            end else begin
              byte_q  <= byte_q + 4'd1;
              tx_q    <= 1'b0;
              state_q <= StStart;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Saturating count of records refused because the FIFO was full with no pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drop_q <= '0;
    end else if (i_trace_valid && fifo_full && !pop && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign o_tx         = tx_q;
  assign o_trace_full = fifo_full;
  assign o_busy       = (state_q != StIdle) || (fifo_count != '0);
  assign o_drop_cnt   = drop_q;

endmodule

// File: tb/tb_nnrv_trace_tx.sv
// Bench for nnrv_trace_tx: expected frame bytes go into a queue as records are
// issued; a UART receiver process decodes o_tx and compares against the queue.
module tb_nnrv_trace_tx;

  localparam int CPB = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] pc    = '0;
  logic [31:0] instr = '0;
  logic        tx, full, busy;
  logic [7:0]  drop;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] exp_q[$];
  logic [7:0] single_bytes [9] = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h00,
                                   8'h93, 8'h00, 8'h50, 8'h00};

  nnrv_trace_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .XLEN         (32)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_trace_valid (valid),
    .i_trace_pc    (pc),
    .i_trace_instr (instr),
    .o_tx          (tx),
    .o_trace_full  (full),
    .o_busy        (busy),
    .o_drop_cnt    (drop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the negedge at which 'c' rising edges have occurred.
  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Queue the first nbytes of the frame for record (p, i).
  task automatic expect_frame(input logic [31:0] p, input logic [31:0] i, input int nbytes);
    logic [63:0] r;
    r = {i, p};
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 8 && k < nbytes - 1; k++) exp_q.push_back(r[8*k +: 8]);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check({name, "_busy_low"}, busy, 1'b0);
    repeat (5) @(negedge clk);
    check({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // UART receiver: detect start, sample mid-bit, discard bytes overlapped by reset.
  initial begin : monitor
    logic [7:0] b;
    logic       ok;
    logic       stop_bit;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        ok = 1'b1;
        repeat (CPB + CPB / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          b[k] = tx;
          ok   = ok & rst_n;
          if (k < 7) repeat (CPB) @(negedge clk);
        end
        repeat (CPB) @(negedge clk);
        stop_bit = tx;
        ok       = ok & rst_n;
        if (ok) begin
          check("rx_stop_bit", stop_bit, 1'b1);
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rx_unexpected_byte: got 0x%0h, expected no byte", b);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", b, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t0, bad, n;

    // Reset
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_drop", drop, 8'd0);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_bad_cycles", bad, 0);

    // Single record: latency, frame bytes, frame length
    @(negedge clk);
    t0 = cyc;
    valid = 1'b1; pc = 32'h0000_0004; instr = 32'h0050_0093;
    foreach (single_bytes[k]) exp_q.push_back(single_bytes[k]);
    goto(t0 + 1);
    valid = 1'b0;
    check("single_tx_n1", tx, 1'b1);
    check("single_busy_n1", busy, 1'b1);
    goto(t0 + 2);
    check("single_tx_n2", tx, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("single_busy_cycles", n, 360);
    drain("single");

    // Overflow: 7 back-to-back records, records 0..4 kept, 5 and 6 dropped
    @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < 7; i++) begin
      goto(t0 + i);
      if (i == 4) check("ovf_full_cnt3", full, 1'b0);
      if (i == 5) check("ovf_full_cnt4", full, 1'b1);
      if (i == 6) check("ovf_drop_1", drop, 8'd1);
      valid = 1'b1;
      pc    = 32'h0000_0100 + 32'(4 * i);
      instr = 32'h0010_0093 + 32'(i);
      if (i < 5) expect_frame(pc, instr, 9);
    end
    goto(t0 + 7);
    valid = 1'b0;
    check("ovf_drop_2", drop, 8'd2);
    check("ovf_full_hold", full, 1'b1);

    // Push at full on the idle cycle between frames (coincident pop)
    goto(t0 + 362);
    check("coinc_full_before", full, 1'b1);
    check("coinc_idle_tx", tx, 1'b1);
    valid = 1'b1; pc = 32'h0000_0180; instr = 32'h0000_0033;
    expect_frame(pc, instr, 9);
    goto(t0 + 363);
    valid = 1'b0;
    check("coinc_full_after", full, 1'b1);
    check("coinc_drop_same", drop, 8'd2);
    check("coinc_next_start", tx, 1'b0);
    drain("overflow");

    // Two queued records: stop bit plus exactly one idle cycle between frames
    @(negedge clk);
    t0 = cyc;
    valid = 1'b1; pc = 32'h0000_0200; instr = 32'h00A0_0113;
    expect_frame(pc, instr, 9);
    goto(t0 + 1);
    pc = 32'h0000_0204; instr = 32'h0020_81B3;
    expect_frame(pc, instr, 9);
    goto(t0 + 2);
    valid = 1'b0;
    goto(t0 + 1 + 356);
    check("gap_last_data_bit", tx, 1'b0);
    goto(t0 + 1 + 357);
    n = 0;
    while (tx === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("gap_high_run", n, 5);
    drain("gap");

    // Reset during data bits of byte 3: only bytes 0..2 ever reach the line intact
    @(negedge clk);
    t0 = cyc;
    valid = 1'b1; pc = 32'h0000_0300; instr = 32'h0030_8193;
    expect_frame(pc, instr, 3);
    goto(t0 + 1);
    valid = 1'b0;
    goto(t0 + 1 + 130);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_full", full, 1'b0);
    check("midrst_drop", drop, 8'd0);
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("midrst_idle_bad_cycles", bad, 0);
    check("midrst_queue_empty", exp_q.size(), 0);

    // 300 drops saturate the counter at 255
    @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < 305; i++) begin
      goto(t0 + i);
      if (i == 259) check("sat_drop_254", drop, 8'd254);
      if (i == 261) check("sat_drop_255", drop, 8'd255);
      valid = 1'b1;
      pc    = 32'h0000_1000 + 32'(4 * i);
      instr = 32'h0000_0013;
      if (i < 5) expect_frame(pc, instr, 9);
    end
    goto(t0 + 305);
    valid = 1'b0;
    check("sat_drop_final", drop, 8'd255);
    drain("sat");
    check("final_tx", tx, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
